// File: rtl/gpio_in_debouncer_pkg.sv
// Board-level constants shared by the GPIO input conditioning logic.
//   CLK_FREQ_HZ        system clock frequency
//   DEBOUNCE_10MS      clock cycles in 10 ms, the default debounce window
//   GPIO_IN_WIDTH_0..2 widths of the SWS / JBI / BTNS input groups
//   cnt_width()        width of a counter that must hold 0 .. cycles-1 (min 1)
package gpio_in_debouncer_pkg;

  localparam int CLK_FREQ_HZ     = 100_000_000;
  localparam int DEBOUNCE_10MS   = CLK_FREQ_HZ / 100;
  localparam int GPIO_IN_WIDTH_0 = 8;
  localparam int GPIO_IN_WIDTH_1 = 4;
  localparam int GPIO_IN_WIDTH_2 = 4;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_debouncer_debounce_bit.sv
// One-bit input conditioner: synchroniser chain, stability counter, clean
// level register and registered rise/fall pulses.
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   raw    in   raw pin level, asynchronous to clock
//   clean  out  debounced level
//   rise   out  one-cycle pulse in the cycle clean goes 0->1
//   fall   out  one-cycle pulse in the cycle clean goes 1->0
//   flip   out  combinational: clean changes at the next edge (feeds the
//               parent's registered any_change so it lines up with the pulses)
module debounce_bit
  import gpio_in_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit RESET_BIT       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic flip
);

  localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   s;
  logic                   differs;
  logic                   at_max;

  // Stage 0: metastability chain, oldest sample in the top bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  assign s       = sync_p0[SYNC_STAGES-1];
  assign differs = (s != clean);
  assign at_max  = (cnt_p1 == CNT_MAX);
  assign flip    = differs && at_max;

  // Stage 1: stability counter; any sample equal to clean restarts the window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p1 <= '0;
      clean  <= RESET_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      if (!differs || at_max) begin
        cnt_p1 <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
      if (flip) begin
        clean <= s;
      end
      rise <= flip &&  s;
      fall <= flip && !s;
    end
  end

endmodule

// File: rtl/gpio_in_debouncer.sv
// GPIO input conditioning between board pins and the core's io_gpio_in_*
// ports: WIDTH independent synchronise+debounce channels plus a combined
// change flag.
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   raw_in      in   [WIDTH] raw pin levels, asynchronous to clock
//   clean_out   out  [WIDTH] debounced levels
//   rise_pulse  out  [WIDTH] one-cycle pulse per bit on 0->1 of clean_out
//   fall_pulse  out  [WIDTH] one-cycle pulse per bit on 1->0 of clean_out
//   any_change  out  high in the cycle any rise/fall pulse is high
module gpio_in_debouncer
  import gpio_in_debouncer_pkg::*;
#(
  parameter int               WIDTH           = GPIO_IN_WIDTH_0,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] flip;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[g])
    ) u_bit (
      .clock (clock),
      .reset (reset),
      .raw   (raw_in[g]),
      .clean (clean_out[g]),
      .rise  (rise_pulse[g]),
      .fall  (fall_pulse[g]),
      .flip  (flip[g])
    );
  end

  // Stage 1: registered from the same flip terms as the per-bit pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |flip;
    end
  end

endmodule

// File: tb/tb_gpio_in_debouncer.sv
module tb_gpio_in_debouncer;

  logic       clock;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] c4, r4, f4;
  logic       a4;
  logic [3:0] c1, r1, f1;
  logic       a1;

  int vectors;
  int miscompares;

  // Reference model state (index 0: D=4 build, index 1: D=1 build)
  int         dv [2];
  logic [3:0] rawh[$];
  int         n_edge;
  logic [3:0] mclean [2];
  logic [3:0] mrise  [2];
  logic [3:0] mfall  [2];
  logic       many   [2];
  int         first_ok [2][4];

  gpio_in_debouncer #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0)) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in),
    .clean_out(c4), .rise_pulse(r4), .fall_pulse(f4), .any_change(a4));

  gpio_in_debouncer #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(4'h0)) dut1 (
    .clock(clock), .reset(reset), .raw_in(raw_in),
    .clean_out(c1), .rise_pulse(r1), .fall_pulse(f1), .any_change(a1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Synchronised level seen by the debouncer at edge k after reset release:
  // the raw value sampled two edges earlier, reset value before that.
  function automatic logic [3:0] s_at(input int k);
    if (k >= 2) return rawh[k-2];
    return 4'h0;
  endfunction

  task automatic model_reset();
    rawh.delete();
    n_edge = 0;
    for (int m = 0; m < 2; m++) begin
      mclean[m] = 4'h0;
      mrise[m]  = 4'h0;
      mfall[m]  = 4'h0;
      many[m]   = 1'b0;
      for (int b = 0; b < 4; b++) first_ok[m][b] = 0;
    end
  endtask

  // A bit flips at edge n when the synchronised level has disagreed with the
  // clean level on each of the last D edges, all of them after its previous flip.
  task automatic model_edge(input logic [3:0] r);
    logic [3:0] sv;
    logic       ok;
    int         lo;
    rawh.push_back(r);
    for (int m = 0; m < 2; m++) begin
      mrise[m] = 4'h0;
      mfall[m] = 4'h0;
      lo = n_edge - dv[m] + 1;
      for (int b = 0; b < 4; b++) begin
        ok = (lo >= 0) && (lo >= first_ok[m][b]);
        for (int k = lo; k <= n_edge; k++) begin
          if (k >= 0) begin
            sv = s_at(k);
            if (sv[b] == mclean[m][b]) ok = 1'b0;
          end
        end
        if (ok) begin
          if (mclean[m][b]) mfall[m][b] = 1'b1;
          else              mrise[m][b] = 1'b1;
          mclean[m][b] = ~mclean[m][b];
          first_ok[m][b] = n_edge + 1;
        end
      end
      many[m] = |(mrise[m] | mfall[m]);
    end
    n_edge++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " d4 clean"}, c4, mclean[0]);
    chk({tag, " d4 rise"},  r4, mrise[0]);
    chk({tag, " d4 fall"},  f4, mfall[0]);
    chk({tag, " d4 any"},   {3'b0, a4}, {3'b0, many[0]});
    chk({tag, " d1 clean"}, c1, mclean[1]);
    chk({tag, " d1 rise"},  r1, mrise[1]);
    chk({tag, " d1 fall"},  f1, mfall[1]);
    chk({tag, " d1 any"},   {3'b0, a1}, {3'b0, many[1]});
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    raw_in = r;
    @(posedge clock);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rv;
    vectors     = 0;
    miscompares = 0;
    dv[0] = 4;
    dv[1] = 1;
    model_reset();

    // Reset held with all pins high
    reset  = 1'b1;
    raw_in = 4'hF;
    repeat (3) @(posedge clock);
    #1;
    chk("rst clean", c4, 4'h0);
    chk("rst rise",  r4, 4'h0);
    chk("rst fall",  f4, 4'h0);
    chk("rst any",   {3'b0, a4}, 4'h0);
    chk("rst d1 clean", c1, 4'h0);
    reset = 1'b0;

    // All bits rise together
    for (int i = 0; i < 7; i++) begin
      step(4'hF, "t1");
      if (i == 4) chk("t1 clean before edge5", c4, 4'h0);
      if (i == 5) begin
        chk("t1 clean at edge5", c4, 4'hF);
        chk("t1 rise at edge5",  r4, 4'hF);
        chk("t1 any at edge5",   {3'b0, a4}, 4'h1);
      end
      if (i == 6) chk("t1 rise one cycle", r4, 4'h0);
      if (i == 1) chk("t1 d1 clean edge1", c1, 4'h0);
      if (i == 2) chk("t1 d1 clean edge2", c1, 4'hF);
    end

    // All bits fall together
    for (int i = 0; i < 7; i++) begin
      step(4'h0, "t3");
      if (i == 5) chk("t3 fall at edge5", f4, 4'hF);
      if (i == 6) begin
        chk("t3 fall one cycle", f4, 4'h0);
        chk("t3 clean low",      c4, 4'h0);
      end
    end

    // Bit 0 bounces: runs of 3 never reach the 4-cycle window
    for (int i = 0; i < 11; i++) begin
      rv = (i < 3 || (i >= 4 && i < 7)) ? 4'h1 : 4'h0;
      step(rv, "t2");
      chk("t2 clean stays", c4, 4'h0);
      chk("t2 no rise",     r4, 4'h0);
    end

    // Bit 1 rises while bit 2 falls on the same edge
    for (int i = 0; i < 7; i++) step(4'b0100, "t4a");
    for (int i = 0; i < 7; i++) begin
      step(4'b0010, "t4");
      if (i == 5) begin
        chk("t4 rise", r4, 4'b0010);
        chk("t4 fall", f4, 4'b0100);
        chk("t4 any",  {3'b0, a4}, 4'h1);
      end
    end

    // Reset mid-count while clean is all ones
    for (int i = 0; i < 7; i++) step(4'hF, "t5a");
    for (int i = 0; i < 4; i++) step(4'h0, "t5b");
    reset = 1'b1;
    #1;
    chk("t5 async clean", c4, 4'h0);
    chk("t5 async rise",  r4, 4'h0);
    chk("t5 async fall",  f4, 4'h0);
    chk("t5 async any",   {3'b0, a4}, 4'h0);
    raw_in = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      step(4'hF, "t5");
      if (i == 5) chk("t5 rise after release", r4, 4'hF);
    end

    // Random slowly-toggling pins, both builds against the model
    rv = raw_in;
    for (int i = 0; i < 10000; i++) begin
      rv = rv ^ 4'($urandom & $urandom);
      step(rv, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
